// File: rtl/bank_group_rr_arbiter.sv
// Round-robin arbiter granting one bank group at a time the shared command/data path.
// Tenures end on request drop, burst limit or timeout; a programmable gap separates grants.
module bank_group_rr_arbiter #(
  parameter int unsigned NUM_GROUPS        = 4,
  parameter int unsigned MAX_BURSTS        = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 32,
  parameter int unsigned TURNAROUND_CYCLES = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_GROUPS-1:0]             req,
  input  logic [NUM_GROUPS-1:0]             done,
  output logic [NUM_GROUPS-1:0]             grant,
  output logic                              grant_valid,
  output logic [$clog2(NUM_GROUPS)-1:0]     sel,
  output logic [$clog2(MAX_BURSTS+1)-1:0]   burst_cnt,
  output logic                              timeout,
  output logic                              stray_done
);

  localparam int unsigned SEL_W = $clog2(NUM_GROUPS);
  localparam int unsigned BC_W  = $clog2(MAX_BURSTS + 1);
  localparam int unsigned TM_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GAP_W = (TURNAROUND_CYCLES < 2) ? 1 : $clog2(TURNAROUND_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [TM_W-1:0]  timer_q, timer_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [NUM_GROUPS-1:0] grant_d;
  logic [SEL_W-1:0]      sel_d;
  logic [BC_W-1:0]       burst_d;
  logic                  timeout_d;
  logic                  stray_d;

  logic             release_c;
  logic             arb_c;
  logic             hit_time_c;
  logic             hit_burst_c;
  logic             done_g_c;
  logic [SEL_W-1:0] ptr_inc_c;
  logic [SEL_W-1:0] arb_ptr_c;
  logic [SEL_W-1:0] winner_c;

  // First requesting group at or after p, wrapping around.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_GROUPS-1:0] r,
                                               input logic [SEL_W-1:0]      p);
    logic [SEL_W-1:0] w;
    logic             found;
    int unsigned      idx;
    w     = p;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
      idx = (32'(p) + i) % NUM_GROUPS;
      if (!found && r[SEL_W'(idx)]) begin
        w     = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign done_g_c  = done[sel];
  assign ptr_inc_c = (32'(sel) == NUM_GROUPS - 1) ? '0 : sel + SEL_W'(1);
  // A zero-gap handoff arbitrates from the post-release pointer in the same edge.
  assign arb_ptr_c = (state_q == S_GRANT) ? ptr_inc_c : ptr_q;
  assign winner_c  = rr_pick(req, arb_ptr_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      sel         <= '0;
      burst_cnt   <= '0;
      timeout     <= 1'b0;
      stray_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      grant       <= grant_d;
      grant_valid <= |grant_d;
      sel         <= sel_d;
      burst_cnt   <= burst_d;
      timeout     <= timeout_d;
      stray_done  <= stray_d;
    end
  end

  // Next state plus release/arbitration decisions.
  always_comb begin
    state_d     = state_q;
    release_c   = 1'b0;
    arb_c       = 1'b0;
    hit_time_c  = 1'b0;
    hit_burst_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_GRANT;
          arb_c   = 1'b1;
        end
      end
      S_GRANT: begin
        hit_time_c  = (32'(timer_q) == TIMEOUT_CYCLES - 1);
        hit_burst_c = done_g_c && (32'(burst_cnt) + 32'd1 == MAX_BURSTS);
        release_c   = !req[sel] || hit_burst_c || hit_time_c;
        if (release_c) begin
          if (TURNAROUND_CYCLES > 0) begin
            state_d = S_GAP;
          end else if (|req) begin
            arb_c = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (32'(gap_q) == TURNAROUND_CYCLES - 1) begin
          if (|req) begin
            state_d = S_GRANT;
            arb_c   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath counters.
  always_comb begin
    grant_d   = grant;
    sel_d     = sel;
    burst_d   = burst_cnt;
    timer_d   = timer_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    stray_d   = stray_done;

    if (state_q == S_GRANT) begin
      timer_d = timer_q + TM_W'(1);
      if (done_g_c) begin
        burst_d = burst_cnt + BC_W'(1);
      end
      if (|(done & ~grant)) begin
        stray_d = 1'b1;
      end
    end else if (|done) begin
      stray_d = 1'b1;
    end

    if (state_q == S_GAP) begin
      gap_d = gap_q + GAP_W'(1);
    end

    if (release_c) begin
      grant_d   = '0;
      ptr_d     = ptr_inc_c;
      timeout_d = hit_time_c;
      gap_d     = '0;
    end

    if (arb_c) begin
      grant_d = NUM_GROUPS'(1) << winner_c;
      sel_d   = winner_c;
      burst_d = '0;
      timer_d = '0;
    end
  end

endmodule

// File: tb/tb_bank_group_rr_arbiter.sv
// Bench for bank_group_rr_arbiter: directed scenarios plus randomized traffic against
// an event-level model, on one instance with a 1-cycle gap and one with zero gap.
module tb_bank_group_rr_arbiter;

  localparam int NG = 4;
  localparam int MB = 4;
  localparam int TO = 32;
  localparam int TA [2] = '{1, 0};

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done_a, done_b;

  logic [3:0] grant_a, grant_b;
  logic       gv_a, gv_b;
  logic [1:0] sel_a, sel_b;
  logic [2:0] bc_a, bc_b;
  logic       to_a, to_b;
  logic       sd_a, sd_b;

  int total = 0;
  int bad   = 0;

  bank_group_rr_arbiter #(
    .NUM_GROUPS(NG), .MAX_BURSTS(MB), .TIMEOUT_CYCLES(TO), .TURNAROUND_CYCLES(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done_a),
    .grant(grant_a), .grant_valid(gv_a), .sel(sel_a), .burst_cnt(bc_a),
    .timeout(to_a), .stray_done(sd_a)
  );

  bank_group_rr_arbiter #(
    .NUM_GROUPS(NG), .MAX_BURSTS(MB), .TIMEOUT_CYCLES(TO), .TURNAROUND_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done_b),
    .grant(grant_b), .grant_valid(gv_b), .sel(sel_b), .burst_cnt(bc_b),
    .timeout(to_b), .stray_done(sd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] o_grant [2];
  logic       o_gv    [2];
  logic [1:0] o_sel   [2];
  logic [2:0] o_bc    [2];
  logic       o_to    [2];
  logic       o_sd    [2];
  assign o_grant[0] = grant_a; assign o_grant[1] = grant_b;
  assign o_gv[0]    = gv_a;    assign o_gv[1]    = gv_b;
  assign o_sel[0]   = sel_a;   assign o_sel[1]   = sel_b;
  assign o_bc[0]    = bc_a;    assign o_bc[1]    = bc_b;
  assign o_to[0]    = to_a;    assign o_to[1]    = to_b;
  assign o_sd[0]    = sd_a;    assign o_sd[1]    = sd_b;

  // Model: owner is the granted group or -1; gap counts remaining idle cycles.
  int m_own [2], m_gap [2], m_ptr [2], m_age [2], m_bur [2], m_sel [2];
  bit m_to [2], m_stray [2];

  function automatic int pick(input int p, input logic [3:0] r);
    logic [3:0] sh;
    for (int i = 0; i < NG; i++) begin
      sh = r >> ((p + i) % NG);
      if (sh[0]) return (p + i) % NG;
    end
    return -1;
  endfunction

  task automatic model_edge(input int k, input logic [3:0] r, input logic [3:0] d, input logic rn);
    int  g, w;
    bit  try_arb;
    if (!rn) begin
      m_own[k] = -1; m_gap[k] = 0; m_ptr[k] = 0; m_age[k] = 0;
      m_bur[k] = 0;  m_sel[k] = 0; m_to[k] = 0;  m_stray[k] = 0;
      return;
    end
    m_to[k] = 0;
    try_arb = 0;
    if (m_own[k] >= 0) begin
      g = m_own[k];
      if ((d & ~(4'b0001 << g)) != 4'b0) m_stray[k] = 1;
      if (d[g]) m_bur[k]++;
      if (m_age[k] == TO - 1) m_to[k] = 1;
      m_age[k]++;
      if (!r[g] || (d[g] && m_bur[k] == MB) || m_to[k]) begin
        m_own[k] = -1;
        m_ptr[k] = (g + 1) % NG;
        if (TA[k] > 0) m_gap[k] = TA[k];
        else try_arb = 1;
      end
    end else begin
      if (d != 4'b0) m_stray[k] = 1;
      if (m_gap[k] > 0) begin
        m_gap[k]--;
        try_arb = (m_gap[k] == 0);
      end else begin
        try_arb = 1;
      end
    end
    if (try_arb) begin
      w = pick(m_ptr[k], r);
      if (w >= 0) begin
        m_own[k] = w; m_sel[k] = w; m_bur[k] = 0; m_age[k] = 0;
      end
    end
  endtask

  // Advance one clock: model sees the inputs the DUTs sample, outputs read at negedge.
  task automatic tick();
    @(posedge clk);
    model_edge(0, req, done_a, rst_n);
    model_edge(1, req, done_b, rst_n);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0; done_a = 4'b0; done_b = 4'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({o_grant[k], o_gv[k], o_sel[k], o_bc[k], o_to[k], o_sd[k]} !== 12'b0) begin
        bad++;
        $display("FAIL reset[%0d] grant=%b gv=%b sel=%0d bc=%0d to=%b sd=%b expected all zero",
                 k, o_grant[k], o_gv[k], o_sel[k], o_bc[k], o_to[k], o_sd[k]);
      end
    end
  endtask

  task automatic test_first_grant();
    req = 4'b0001;
    tick();
    total++;
    if (grant_a !== 4'b0001 || sel_a !== 2'd0 || gv_a !== 1'b1 || bc_a !== 3'd0) begin
      bad++;
      $display("FAIL first_grant grant=%b sel=%0d gv=%b bc=%0d expected 0001/0/1/0",
               grant_a, sel_a, gv_a, bc_a);
    end
  endtask

  task automatic test_burst_limit();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b0101;
    tick();
    for (int i = 0; i < MB; i++) begin
      done_a = 4'b0001;
      tick();
      done_a = 4'b0;
      total++;
      if (i < MB - 1) begin
        if (grant_a !== 4'b0001 || bc_a !== 3'(i + 1)) begin
          bad++;
          $display("FAIL burst_count i=%0d grant=%b bc=%0d expected 0001/%0d", i, grant_a, bc_a, i + 1);
        end
      end else if (grant_a !== 4'b0 || gv_a !== 1'b0 || bc_a !== 3'd4 || sel_a !== 2'd0 || to_a !== 1'b0) begin
        bad++;
        $display("FAIL burst_release grant=%b gv=%b bc=%0d sel=%0d to=%b expected 0000/0/4/0/0",
                 grant_a, gv_a, bc_a, sel_a, to_a);
      end
    end
    tick();
    total++;
    if (grant_a !== 4'b0100 || sel_a !== 2'd2 || bc_a !== 3'd0) begin
      bad++;
      $display("FAIL burst_next grant=%b sel=%0d bc=%0d expected 0100/2/0", grant_a, sel_a, bc_a);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b0010;
    tick();
    pulses = 0;
    for (int e = 1; e <= TO - 1; e++) begin
      tick();
      if (to_a) pulses++;
      if (grant_a !== 4'b0010) begin
        total++; bad++;
        $display("FAIL timeout_hold edge=%0d grant=%b expected 0010", e, grant_a);
      end
    end
    tick();
    total++;
    if (to_a !== 1'b1 || grant_a !== 4'b0 || pulses != 0) begin
      bad++;
      $display("FAIL timeout_edge to=%b grant=%b early_pulses=%0d expected 1/0000/0", to_a, grant_a, pulses);
    end
    tick();
    total++;
    if (to_a !== 1'b0 || grant_a !== 4'b0010 || sel_a !== 2'd1 || bc_a !== 3'd0) begin
      bad++;
      $display("FAIL timeout_regrant to=%b grant=%b sel=%0d bc=%0d expected 0/0010/1/0",
               to_a, grant_a, sel_a, bc_a);
    end
  endtask

  // Continues from the group-1 tenure left by test_timeout (pointer already past 0).
  task automatic test_stray_and_mid_reset();
    done_a = 4'b0010; tick(); done_a = 4'b0;
    done_a = 4'b1000; tick(); done_a = 4'b0;
    total++;
    if (bc_a !== 3'd1 || sd_a !== 1'b1 || grant_a !== 4'b0010) begin
      bad++;
      $display("FAIL stray_set bc=%0d sd=%b grant=%b expected 1/1/0010", bc_a, sd_a, grant_a);
    end
    done_a = 4'b0010; tick(); done_a = 4'b0;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (sd_a !== 1'b1 || bc_a !== 3'd2 || grant_a !== 4'b0010) begin
      bad++;
      $display("FAIL stray_sticky sd=%b bc=%0d grant=%b expected 1/2/0010", sd_a, bc_a, grant_a);
    end
    req = 4'b1111;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    total++;
    if ({grant_a, gv_a, sel_a, bc_a, to_a, sd_a} !== 12'b0) begin
      bad++;
      $display("FAIL mid_reset grant=%b gv=%b sel=%0d bc=%0d to=%b sd=%b expected all zero",
               grant_a, gv_a, sel_a, bc_a, to_a, sd_a);
    end
    tick();
    total++;
    if (grant_a !== 4'b0001 || sel_a !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset_ptr grant=%b sel=%0d expected 0001/0", grant_a, sel_a);
    end
  endtask

  // Every group requesting, each finishing a burst every granted cycle.
  task automatic test_rr_order();
    logic [3:0] exp_a, exp_b;
    rst_n = 1'b0; done_a = 4'b0; done_b = 4'b0; tick(); rst_n = 1'b1;
    req = 4'b1111;
    tick();
    for (int c = 0; c < 42; c++) begin
      if (c > 0) begin
        done_a = grant_a; done_b = grant_b;
        tick();
      end
      exp_a = (c % 5 < 4) ? (4'b0001 << ((c / 5) % NG)) : 4'b0;
      exp_b = 4'b0001 << ((c / 4) % NG);
      total++;
      if (grant_a !== exp_a || grant_b !== exp_b) begin
        bad++;
        $display("FAIL rr_order c=%0d grant_a=%b exp=%b grant_b=%b exp=%b", c, grant_a, exp_a, grant_b, exp_b);
      end
    end
    done_a = 4'b0; done_b = 4'b0;
  endtask

  task automatic test_random();
    logic [3:0] eg;
    rst_n = 1'b0; req = 4'b0; done_a = 4'b0; done_b = 4'b0; tick(); rst_n = 1'b1;
    req = 4'($urandom_range(15));
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < NG; g++) if ($urandom_range(15) == 0) req[g] = ~req[g];
      done_a = ($urandom_range(3) == 0) ? grant_a : 4'b0;
      done_b = ($urandom_range(3) == 0) ? grant_b : 4'b0;
      if ($urandom_range(150) == 0) done_a = done_a | 4'(1 << $urandom_range(3));
      if ($urandom_range(150) == 0) done_b = done_b | 4'(1 << $urandom_range(3));
      rst_n = ($urandom_range(400) != 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        eg = (m_own[k] >= 0) ? (4'b0001 << m_own[k]) : 4'b0;
        total++;
        if (o_grant[k] !== eg || o_gv[k] !== (m_own[k] >= 0) || o_sel[k] !== 2'(m_sel[k]) ||
            o_bc[k] !== 3'(m_bur[k]) || o_to[k] !== m_to[k] || o_sd[k] !== m_stray[k]) begin
          bad++;
          $display("FAIL random[%0d] c=%0d grant=%b/%b gv=%b sel=%0d/%0d bc=%0d/%0d to=%b/%b sd=%b/%b (got/exp)",
                   k, c, o_grant[k], eg, o_gv[k], o_sel[k], m_sel[k], o_bc[k], m_bur[k],
                   o_to[k], m_to[k], o_sd[k], m_stray[k]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_burst_limit();
    test_timeout();
    test_stray_and_mid_reset();
    test_rr_order();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
